// File: rtl/eth_pkg.sv
// eth_pkg: shared types and constants for the egress port
package eth_pkg;
  localparam int DATA_W = 32;
  localparam int CHECKSUM_W = 32;
  typedef struct packed {
    logic eop;
    logic sop;
    logic [DATA_W-1:0] data;
  } entry_t;
  typedef enum logic [1:0] {W_IDLE, W_RECV, W_DROP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_DATA, R_TRAILER} rd_state_t;
endpackage

// File: rtl/eth_egress_ram.sv
// eth_egress_ram: simple dual-port packet buffer with registered read
module eth_egress_ram
  import eth_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  entry_t        wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output entry_t        rdata
);
  entry_t mem [DEPTH];
  // write port and registered read port; rdata holds when re is low
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/eth_egress_port.sv
// eth_egress_port: store-and-forward egress buffer appending a checksum trailer
module eth_egress_port
  import eth_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic [31:0]              inData,
  input  logic                     inSop,
  input  logic                     inEop,
  output logic [31:0]              txData,
  output logic                     txValid,
  input  logic                     txReady,
  output logic                     txSop,
  output logic                     txEop,
  output logic [$clog2(DEPTH):0]   bufLevel,
  output logic [CNT_W-1:0]         txPktCnt,
  output logic [CNT_W-1:0]         dropPktCnt
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr, commit_ptr, rd_ptr, wp_n, cp_n, base;
  wr_state_t ws, ws_n;
  rd_state_t rs, rs_n;
  logic act, full, drop, we, rd_en, q_vld, ld_q, ld_tr, last_r, hs;
  entry_t wdata, q;
  logic [CHECKSUM_W-1:0] csum;
  assign base = (ws == W_RECV && inSop) ? commit_ptr : wr_ptr;
  assign full = (base - rd_ptr) == (AW+1)'(DEPTH);
  assign act = ws == W_RECV || inSop;
  assign wdata = '{eop: inEop, sop: inSop, data: inData};
  // write FSM: accept, restart on missing eop, or drop on overflow
  always_comb begin
    ws_n = ws;
    wp_n = wr_ptr;
    cp_n = commit_ptr;
    we = 1'b0;
    drop = 1'b0;
    if (act) begin
      if (full) begin
        drop = 1'b1;
        wp_n = commit_ptr;
        ws_n = inEop ? W_IDLE : W_DROP;
      end else begin
        drop = ws == W_RECV && inSop;
        we = 1'b1;
        wp_n = base + 1'b1;
        cp_n = inEop ? base + 1'b1 : commit_ptr;
        ws_n = inEop ? W_IDLE : W_RECV;
      end
    end else if (ws == W_DROP && inEop) begin
      ws_n = W_IDLE;
    end
  end
  // write-side state, pointers and drop counter
  always_ff @(posedge clk) begin
    if (!resetN) begin
      ws <= W_IDLE;
      wr_ptr <= '0;
      commit_ptr <= '0;
      dropPktCnt <= '0;
    end else begin
      ws <= ws_n;
      wr_ptr <= wp_n;
      commit_ptr <= cp_n;
      if (drop && dropPktCnt != '1) dropPktCnt <= dropPktCnt + 1'b1;
    end
  end
  eth_egress_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk(clk),
    .we(we),
    .waddr(base[AW-1:0]),
    .wdata(wdata),
    .re(rd_en),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(q)
  );
  assign hs = txValid && txReady;
  assign txValid = rs != R_IDLE;
  assign txEop = rs == R_TRAILER;
  assign bufLevel = wr_ptr - rd_ptr;
  assign rd_en = rd_ptr != commit_ptr && (!q_vld || ld_q);
  // read FSM: rs names what the output register holds; q is a one-word prefetch
  always_comb begin
    ld_q = 1'b0;
    ld_tr = 1'b0;
    if (rs == R_IDLE) ld_q = q_vld;
    else if (hs) begin
      ld_tr = rs == R_DATA && last_r;
      ld_q = !ld_tr && q_vld;
    end
    rs_n = ld_q ? R_DATA : ld_tr ? R_TRAILER : hs ? R_IDLE : rs;
  end
  // read-side pointer, output register, checksum and tx counter
  always_ff @(posedge clk) begin
    if (!resetN) begin
      rs <= R_IDLE;
      rd_ptr <= '0;
      q_vld <= 1'b0;
      txData <= '0;
      txSop <= 1'b0;
      last_r <= 1'b0;
      csum <= '0;
      txPktCnt <= '0;
    end else begin
      rs <= rs_n;
      rd_ptr <= rd_en ? rd_ptr + 1'b1 : rd_ptr;
      q_vld <= rd_en ? 1'b1 : ld_q ? 1'b0 : q_vld;
      if (ld_q) begin
        txData <= q.data;
        txSop <= q.sop;
        last_r <= q.eop;
        csum <= q.sop ? q.data : csum + q.data;
      end else if (ld_tr) begin
        txData <= csum;
        txSop <= 1'b0;
      end
      if (rs == R_TRAILER && txReady && txPktCnt != '1) txPktCnt <= txPktCnt + 1'b1;
    end
  end
endmodule
